// File: rtl/i2s_tx_sched.sv
// ============================================================================
//  Module      : i2s_tx_sched
//  Description : Sample scheduler in front of an I2S transmitter. Arbitrates
//                between a streaming audio source (src0) and a priority
//                alert/tone source (src1), buffers accepted stereo words in a
//                small FIFO and presents one word per transmitter request.
//                Handles start-up prefill, underrun fill and mute-on-disable.
//  Options     : `define I2S_TX_SCHED_UNDERRUN_REPEAT_EN to repeat the last
//                popped word on underrun instead of sending silence.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_tx_sched #(
    parameter int G_DATA_WIDTH      = 16,
    parameter int G_FIFO_DEPTH_LOG2 = 2
) (
    input  logic                           i_mclk,
    input  logic                           i_mclk_rst,
    input  logic                           i_enable,
    input  logic                           i_src0_valid,
    input  logic [2*G_DATA_WIDTH-1:0]      i_src0_data,
    output logic                           o_src0_ready,
    input  logic                           i_src1_valid,
    input  logic [2*G_DATA_WIDTH-1:0]      i_src1_data,
    output logic                           o_src1_ready,
    input  logic                           i_tx_ready,
    output logic [2*G_DATA_WIDTH-1:0]      o_tx_data,
    output logic [G_FIFO_DEPTH_LOG2:0]     o_fifo_level,
    output logic [15:0]                    o_underrun_cnt,
    output logic                           o_running
);

    localparam int c_w2        = 2 * G_DATA_WIDTH;
    localparam int c_depth     = 1 << G_FIFO_DEPTH_LOG2;
    // Pointers need at least one bit even for a single-entry FIFO.
    localparam int c_aw        = (G_FIFO_DEPTH_LOG2 > 0) ? G_FIFO_DEPTH_LOG2 : 1;
    localparam int c_mem_words = 1 << c_aw;
    localparam int c_lw        = G_FIFO_DEPTH_LOG2 + 1;

    localparam logic [c_lw-1:0] c_full_level = c_lw'(c_depth);
    // Half-full prefill threshold; a single-entry FIFO starts after one word.
    localparam logic [c_lw-1:0] c_prefill_th =
        (G_FIFO_DEPTH_LOG2 == 0) ? c_lw'(1) : c_lw'(c_depth / 2);
    localparam logic [c_aw-1:0] c_last_ptr   = c_aw'(c_depth - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PREFILL = 2'd1;
    localparam logic [1:0] S_RUN     = 2'd2;

    logic [1:0]        r_state;
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_lw-1:0]   r_level;
    logic [c_w2-1:0]   r_tx_data;
    logic [15:0]       r_underrun_cnt;
    logic [c_w2-1:0]   r_mem [c_mem_words];

    logic              w_full;
    logic              w_empty;
    logic              w_active;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_push;
    logic [c_w2-1:0]   w_push_data;
    logic              w_pop;
    logic              w_underrun;
    logic [c_w2-1:0]   w_filler;
    logic [c_aw-1:0]   w_wr_ptr_nxt;
    logic [c_aw-1:0]   w_rd_ptr_nxt;

    // Full/empty and grants come from registered level/state only, so a pop
    // in the same cycle never frees a slot for a push.
    assign w_full      = (r_level == c_full_level);
    assign w_empty     = (r_level == '0);
    assign w_active    = (r_state != S_IDLE);
    assign w_grant1    = i_src1_valid & ~w_full & w_active;
    assign w_grant0    = i_src0_valid & ~w_full & w_active & ~i_src1_valid;
    assign w_push      = w_grant0 | w_grant1;
    assign w_push_data = w_grant1 ? i_src1_data : i_src0_data;
    assign w_pop       = (r_state == S_RUN) & i_tx_ready & ~w_empty;
    // A word pushed into an empty FIFO this cycle is not bypassed: still an underrun.
    assign w_underrun  = (r_state == S_RUN) & i_tx_ready & w_empty;

    assign w_wr_ptr_nxt = (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + c_aw'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + c_aw'(1);

`ifdef I2S_TX_SCHED_UNDERRUN_REPEAT_EN
    // The presented word only changes on a pop, an underrun fill (which
    // repeats it) or a flush to zero, so it always equals the last popped word.
    assign w_filler = r_tx_data;
`else
    assign w_filler = '0;
`endif

    // FIFO storage; contents need no reset since level/pointers qualify them.
    always_ff @(posedge i_mclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    // Control state, FIFO pointers/level, presented word and underrun counter.
    always_ff @(posedge i_mclk) begin
        if (i_mclk_rst) begin
            r_state        <= S_IDLE;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_tx_data      <= '0;
            r_underrun_cnt <= '0;
        end else if (!i_enable) begin
            // Mute and flush; the underrun statistic survives a disable.
            r_state   <= S_IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_tx_data <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_pop) begin
                r_rd_ptr  <= w_rd_ptr_nxt;
                r_tx_data <= r_mem[r_rd_ptr];
            end
            r_level <= r_level + c_lw'(w_push) - c_lw'(w_pop);

            if (w_underrun) begin
                r_tx_data <= w_filler;
                if (r_underrun_cnt != 16'hFFFF) begin
                    r_underrun_cnt <= r_underrun_cnt + 16'd1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    r_state <= S_PREFILL;
                end
                S_PREFILL: begin
                    if (r_level >= c_prefill_th) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_underrun) begin
                        r_state <= S_PREFILL;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_src0_ready   = w_grant0;
    assign o_src1_ready   = w_grant1;
    assign o_tx_data      = r_tx_data;
    assign o_fifo_level   = r_level;
    assign o_underrun_cnt = r_underrun_cnt;
    assign o_running      = (r_state == S_RUN);

endmodule

`default_nettype wire

// File: doc/i2s_tx_sched.md
# i2s_tx_sched

Sample scheduler in front of the I2S transmitter. It arbitrates between two stereo sample sources: a streaming audio source and a higher-priority alert/tone source. Accepted samples are buffered in a small FIFO, and the next stereo word is presented to the transmitter each time it requests one. It also manages start-up prefill, underrun fill and mute-on-disable, all in the master-clock domain.

## Interface
- G_DATA_WIDTH, 16, bits per channel; stereo word width W2 = 2*G_DATA_WIDTH (left in MSBs).
- G_FIFO_DEPTH_LOG2, 2, FIFO depth = 2**G_FIFO_DEPTH_LOG2 words (minimum 1).

Ports:
- i_mclk  in  1  master clock; one clock for the whole block.
- i_mclk_rst  in  1  reset, synchronous, active-high.
- i_enable  in  1  scheduler enable; low = mute and flush.
- i_src0_valid  in  1  audio stream word valid.
- i_src0_data  in  W2  audio stream stereo word.
- o_src0_ready  out  1  audio word accepted this cycle when valid&ready.
- i_src1_valid  in  1  alert/tone word valid (priority source).
- i_src1_data  in  W2  alert/tone stereo word.
- o_src1_ready  out  1  alert word accepted this cycle when valid&ready.
- i_tx_ready  in  1  single-cycle pulse from transmitter (already synchronised to i_mclk): current word consumed, next word required.
- o_tx_data  out  W2  word presented to transmitter.
- o_fifo_level  out  G_FIFO_DEPTH_LOG2+1  current FIFO occupancy.
- o_underrun_cnt  out  16  saturating underrun counter.
- o_running  out  1  high in S_RUN.

## Operation
- States: S_IDLE, S_PREFILL, S_RUN.
- S_IDLE:
  - Entered from reset, or whenever i_enable is low (from any state, next edge).
  - FIFO flushed, both src readies low, o_tx_data = 0.
  - i_enable high moves the state to S_PREFILL.
- S_PREFILL:
  - Sources are accepted; i_tx_ready pulses leave o_tx_data unchanged and are not counted.
  - Move to S_RUN when level >= 2**(G_FIFO_DEPTH_LOG2-1). With depth 1 the threshold is 1.
- S_RUN:
  - On i_tx_ready with level > 0: pop the head into o_tx_data.
  - On i_tx_ready with level = 0 (underrun): load the filler word into o_tx_data, increment o_underrun_cnt (saturating at 0xFFFF), go to S_PREFILL.
- Arbitration, fixed priority (push at most one word per cycle):
  - grant1 = i_src1_valid & !full & state!=S_IDLE.
  - grant0 = i_src0_valid & !full & state!=S_IDLE & !i_src1_valid.
  - o_srcN_ready = grantN, combinational from registered full/state.
- Full uses the registered level. A push is refused when full even if a pop occurs the same cycle.
- Simultaneous push and pop (not full, not empty): level unchanged, order preserved.
- Push into an empty FIFO and pop in the same cycle (S_RUN): counts as underrun. The pushed word is stored and is not bypassed.
- FIFO pointers wrap modulo depth; level is computed with an extra MSB so full and empty are distinguishable.
- Filler word: 0 (see Configuration).

## Timing
- Reset values: o_tx_data = 0, o_fifo_level = 0, o_underrun_cnt = 0, o_running = 0, o_src0_ready = o_src1_ready = 0, state S_IDLE.
- Reset mid-operation: all of the above take effect on the next edge; FIFO contents are discarded.
- Pop latency: i_tx_ready at cycle N → o_tx_data updated at edge N+1, stable until the next pulse.
- Push latency: word accepted at cycle N → counted in o_fifo_level at N+1 → poppable from N+1.
- Prefill exit: level reaching the threshold at edge N → o_running high at edge N+1.
- i_enable low at cycle N: S_IDLE, o_tx_data = 0, level = 0 at edge N+1. o_underrun_cnt is held, not cleared.

## Configuration
- I2S_TX_SCHED_UNDERRUN_REPEAT_EN
- Defined: the underrun filler is the last word popped (0 if nothing has been popped since the last reset or S_IDLE).
- Undefined: the filler is always 0 (silence).
- Underrun counting and the state transition are identical in both builds.

## Test plan
- Reset then enable, W=16, depth 4: push 0x11112222 and 0x33334444 from src0 → o_running high one cycle after level = 2. Two i_tx_ready pulses → o_tx_data = 0x11112222, then 0x33334444, each one cycle after its pulse.
- Simultaneous valid, src0 = 0xAAAA0000 and src1 = 0xBBBB0000 → src1 accepted first, src0 ready low that cycle. Pops return 0xBBBB0000 then 0xAAAA0000.
- Fill 4 words with no pops → level = 4, both readies low. A pop plus a valid source in the same cycle → no push, level = 3.
- In S_RUN with an empty FIFO, i_tx_ready pulse → o_underrun_cnt = 1, state S_PREFILL, o_tx_data = 0 (macro undefined) or the last popped word (macro defined).
- i_enable dropped with level 3 → next cycle level = 0, o_tx_data = 0, readies low, underrun count unchanged. Force count to 0xFFFF, then one more underrun → stays at 0xFFFF.
- i_mclk_rst asserted mid-stream for one cycle → all outputs at reset values on the next edge; state S_IDLE.
